uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 15 +
 rtl/baud_gen.sv | 35 +++
 rtl/uart_tx.sv | 114 +++++++++++
 tb/tb_uart_tx.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and receiver: FSM encoding, frame width, default bit period.
// Holds types and constants only; no latency and no flow control of its own.
package uart_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS            = 8;
    localparam int BIT_CNT_W            = $clog2(DATA_BITS);
    localparam int BAUD_CNT_W           = 16;
    localparam int CLKS_PER_BIT_DEFAULT = 5208;
endpackage

// File: rtl/baud_gen.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and pulses wrap on the last count; clr restarts it at 0.
// Free running with no backpressure; wrap is combinational from the registered count.
module baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic wrap
);
    localparam logic [BAUD_CNT_W-1:0] LAST = BAUD_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_CNT_W-1:0] ONE  = BAUD_CNT_W'(1);

    logic [BAUD_CNT_W-1:0] cnt_q;
    logic [BAUD_CNT_W-1:0] cnt_d;

    always_comb begin
        wrap = (cnt_q == LAST);
        if (clr || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: tx drops the cycle after valid&&ready, each bit lasts CLKS_PER_BIT cycles.
// ready is low for 10*CLKS_PER_BIT+1 cycles per frame; valid while busy is ignored, nothing is queued.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 busy,
    output logic                 tx
);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] ONE_BIT  = BIT_CNT_W'(1);

    uart_state_t          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 accept;
    logic                 wrap;

    assign accept = valid && ready_q;

    baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .wrap (wrap)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d   = ST_START;
                    shift_d   = data;
                    bit_cnt_d = '0;
                    tx_d      = 1'b0;
                end
            end
            ST_START: begin
                if (wrap) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (wrap) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = ST_STOP;
                        bit_cnt_d = '0;
                        tx_d      = 1'b1;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + ONE_BIT;
                        tx_d      = shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                // bit_cnt marks the stop bit as finished; one more high cycle before ready returns
                tx_d = 1'b1;
                if (bit_cnt_q != '0) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end else if (wrap) begin
                    bit_cnt_d = ONE_BIT;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
                tx_d      = 1'b1;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = !ready_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign tx    = tx_q;
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with CLKS_PER_BIT=4: line waveform model, mid-bit receiver, reset cases.
module tb_uart_tx;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    logic       ready;
    logic       busy;
    logic       tx;

    int errors = 0;
    int checks = 0;

    bit         rx_en = 1'b0;
    int         rx_count = 0;
    logic [7:0] rx_byte;
    logic [7:0] rx_exp;
    logic [7:0] sent_q[$];

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst   (rst),
        .data  (data),
        .valid (valid),
        .ready (ready),
        .busy  (busy),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Expected line level k cycles after acceptance: start bit, data LSB first, stop bit, then idle high.
    function automatic logic exp_tx(input logic [7:0] b, input int k);
        if (k < 0)
            return 1'b1;
        if (k < CPB)
            return 1'b0;
        if (k < 9 * CPB)
            return b[(k - CPB) / CPB];
        return 1'b1;
    endfunction

    // Waits (bounded) for ready, presents b for one edge; returns at the negedge after acceptance.
    task automatic accept(input logic [7:0] b, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (ready === 1'b1) begin
            data  = b;
            valid = 1'b1;
            @(negedge clk);
            valid = 1'b0;
            ok    = 1'b1;
        end
    endtask

    // Independent receiver: samples the line in the middle of each bit.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_en && !rst && tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                checks++;
                if (tx !== 1'b0) begin
                    errors++;
                    $display("FAIL rx_start_mid: tx=%b expected 0", tx);
                end
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    rx_byte[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                checks++;
                if (tx !== 1'b1) begin
                    errors++;
                    $display("FAIL rx_stop_bit: tx=%b expected 1", tx);
                end
                checks++;
                if (sent_q.size() == 0) begin
                    errors++;
                    $display("FAIL rx_extra_frame: got %h with nothing sent", rx_byte);
                end else begin
                    rx_exp = sent_q.pop_front();
                    if (rx_byte !== rx_exp) begin
                        errors++;
                        $display("FAIL rx_byte: got %h expected %h", rx_byte, rx_exp);
                    end
                end
                rx_count++;
            end
        end
    end

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: tx=%b ready=%b busy=%b expected 1 1 0", tx, ready, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            data = 8'($urandom);
            checks++;
            if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold cycle %0d: tx=%b ready=%b busy=%b expected 1 1 0", k, tx, ready, busy);
            end
        end
    endtask

    task automatic test_single_a5();
        bit         ok;
        int         low;
        logic [9:0] seq;
        seq = 10'b1101001010;
        low = 0;
        accept(8'hA5, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL a5_accept: ready never high");
        end
        data = 8'h00;
        for (int k = 0; k < FRAME + 6; k++) begin
            checks++;
            if (tx !== exp_tx(8'hA5, k)) begin
                errors++;
                $display("FAIL a5_tx k=%0d: tx=%b expected %b", k, tx, exp_tx(8'hA5, k));
            end
            if (k % CPB == CPB / 2 && k < FRAME) begin
                checks++;
                if (tx !== seq[k / CPB]) begin
                    errors++;
                    $display("FAIL a5_bit %0d: tx=%b expected %b", k / CPB, tx, seq[k / CPB]);
                end
            end
            checks++;
            if (ready !== (k > FRAME) || busy !== (k <= FRAME)) begin
                errors++;
                $display("FAIL a5_ready k=%0d: ready=%b busy=%b expected %b %b", k, ready, busy, k > FRAME, k <= FRAME);
            end
            if (ready === 1'b0)
                low++;
            @(negedge clk);
        end
        checks++;
        if (low != FRAME + 1) begin
            errors++;
            $display("FAIL a5_ready_low_len: %0d cycles expected %0d", low, FRAME + 1);
        end
    endtask

    task automatic test_back_to_back();
        logic       log_tx[0:99];
        logic [7:0] d0, d1;
        int         n, first2;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        data  = 8'h00;
        valid = 1'b1;
        @(negedge clk);
        data = 8'hFF;
        first2 = -1;
        for (int k = 0; k < 100; k++) begin
            log_tx[k] = tx;
            if (k == FRAME + 2) begin
                checks++;
                if (ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_second_accept: ready=%b expected 0", ready);
                end
                valid = 1'b0;
            end
            if (first2 < 0 && k >= FRAME && tx === 1'b0)
                first2 = k;
            checks++;
            if (tx !== (k < FRAME + 2 ? exp_tx(8'h00, k) : exp_tx(8'hFF, k - FRAME - 2))) begin
                errors++;
                $display("FAIL b2b_tx k=%0d: tx=%b", k, tx);
            end
            @(negedge clk);
        end
        checks++;
        if (first2 != FRAME + 2) begin
            errors++;
            $display("FAIL b2b_gap: second start at %0d expected %0d", first2, FRAME + 2);
        end
        for (int i = 0; i < 8; i++) begin
            d0[i] = log_tx[CPB * (i + 1) + CPB / 2];
            d1[i] = log_tx[FRAME + 2 + CPB * (i + 1) + CPB / 2];
        end
        checks++;
        if (d0 !== 8'h00 || d1 !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_decode: got %h %h expected 00 ff", d0, d1);
        end
    endtask

    task automatic test_ignore_busy();
        bit ok;
        int low;
        low = 0;
        accept(8'h3C, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ign_accept: ready never high");
        end
        for (int k = 0; k < 70; k++) begin
            if (k == 10) begin
                data  = 8'hFF;
                valid = 1'b1;
            end
            if (k == 11)
                valid = 1'b0;
            if (k == 12)
                data = 8'($urandom);
            checks++;
            if (tx !== exp_tx(8'h3C, k)) begin
                errors++;
                $display("FAIL ign_tx k=%0d: tx=%b expected %b", k, tx, exp_tx(8'h3C, k));
            end
            if (ready === 1'b0)
                low++;
            @(negedge clk);
        end
        checks++;
        if (low != FRAME + 1) begin
            errors++;
            $display("FAIL ign_second_frame: ready low %0d cycles expected %0d", low, FRAME + 1);
        end
    endtask

    task automatic test_reset_mid();
        bit         ok;
        logic [7:0] dec;
        accept(8'h81, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rstmid_accept: ready never high");
        end
        for (int k = 0; k < 4 * CPB + 2; k++) begin
            checks++;
            if (tx !== exp_tx(8'h81, k)) begin
                errors++;
                $display("FAIL rstmid_pre k=%0d: tx=%b expected %b", k, tx, exp_tx(8'h81, k));
            end
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: tx=%b ready=%b busy=%b expected 1 1 0", tx, ready, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (tx !== 1'b1 || ready !== 1'b1) begin
                errors++;
                $display("FAIL rstmid_idle: tx=%b ready=%b expected 1 1", tx, ready);
            end
        end
        accept(8'h55, ok);
        for (int k = 0; k < FRAME + 4; k++) begin
            checks++;
            if (tx !== exp_tx(8'h55, k)) begin
                errors++;
                $display("FAIL rstmid_55 k=%0d: tx=%b expected %b", k, tx, exp_tx(8'h55, k));
            end
            if (k % CPB == CPB / 2 && k > CPB && k < 9 * CPB)
                dec[(k - CPB) / CPB] = tx;
            @(negedge clk);
        end
        checks++;
        if (dec !== 8'h55) begin
            errors++;
            $display("FAIL rstmid_decode: got %h expected 55", dec);
        end
    endtask

    task automatic test_loopback();
        bit         ok;
        logic [7:0] b;
        sent_q.delete();
        rx_count = 0;
        rx_en    = 1'b1;
        for (int n = 0; n < 256; n++) begin
            b = 8'($urandom);
            sent_q.push_back(b);
            accept(b, ok);
            if (!ok) begin
                errors++;
                checks++;
                $display("FAIL loop_accept: byte %0d never accepted", n);
                break;
            end
            data = 8'($urandom);
        end
        repeat (60) @(negedge clk);
        rx_en = 1'b0;
        checks++;
        if (rx_count != 256 || sent_q.size() != 0) begin
            errors++;
            $display("FAIL loop_count: received %0d expected 256, %0d unreceived", rx_count, sent_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        test_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
